// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces six raw pushbuttons, turns each
// debounced press into an event, and queues the events in a small FIFO with a
// valid/ready head interface. Lost presses are flagged by a sticky overflow.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] key_raw,
    output logic       key_valid,
    output logic [2:0] key_code,
    input  logic       key_ready,
    output logic [5:0] key_level,
    output logic [2:0] fifo_count,
    output logic       overflow
);

    localparam int          NUM_KEYS   = 6;
    // Queue depth is fixed; pointer and count widths below assume 4 entries.
    localparam int          FIFO_DEPTH = 4;
    localparam logic [15:0] CNT_LAST   = 16'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_key;
    logic [15:0]         deb_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] flip;
    logic [NUM_KEYS-1:0] rose;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] pending_next;
    logic [NUM_KEYS-1:0] push_mask;
    logic [2:0]          fifo_mem [FIFO_DEPTH];
    logic [1:0]          wr_ptr;
    logic [1:0]          rd_ptr;
    logic [1:0]          rd_ptr_next;
    logic                pop;
    logic                push;
    logic [2:0]          push_code;
    logic [2:0]          count_next;
    logic [2:0]          code_next;

    // Two-flop synchronizer on every raw key before anything else looks at it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_key  <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            sync_meta <= key_raw;
            sync_key  <= sync_meta;
        end
    end

    // A key's level flips on its DEBOUNCE_CYCLES-th consecutive disagreeing clock.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            flip[k] = (sync_key[k] != key_level[k]) && (deb_cnt[k] == CNT_LAST);
        end
    end

    // Per-key debounce counter and level; a 0->1 flip is remembered for one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                deb_cnt[k] <= '0;
            end
            key_level <= '0;
            rose      <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sync_key[k] == key_level[k]) begin
                    deb_cnt[k] <= '0;
                end else if (flip[k]) begin
                    deb_cnt[k]   <= '0;
                    key_level[k] <= ~key_level[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 16'd1;
                end
            end
            rose <= flip & ~key_level;
        end
    end

    // Arbitration, FIFO bookkeeping and the next head value.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pop          = key_valid & key_ready;
        push         = 1'b0;
        push_code    = 3'd0;
        push_mask    = '0;
        pending_next = pending;
        count_next   = fifo_count;
        rd_ptr_next  = rd_ptr;
        code_next    = 3'd0;

        // Scanning downward leaves the lowest pending index as the winner.
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                push_code    = 3'(k);
                push_mask    = '0;
                push_mask[k] = 1'b1;
            end
        end

        // A full queue still takes a push when its head leaves on the same clock.
        push = (pending != '0) && ((fifo_count != 3'(FIFO_DEPTH)) || pop);
        if (!push) begin
            push_mask = '0;
        end

        // A press arriving while its key is still pending is dropped.
        pending_next = (pending & ~push_mask) | (rose & ~pending);

        count_next  = fifo_count + {2'b00, push} - {2'b00, pop};
        rd_ptr_next = rd_ptr + {1'b0, pop};

        // Head bypass: the entry being written may become the head immediately.
        if (count_next == 3'd0) begin
            code_next = 3'd0;
        end else if (push && (wr_ptr == rd_ptr_next)) begin
            code_next = push_code;
        end else begin
            code_next = fifo_mem[rd_ptr_next];
        end
    end

    // Pending flags, FIFO pointers, registered head outputs and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            key_valid  <= 1'b0;
            key_code   <= 3'd0;
            overflow   <= 1'b0;
        end else begin
            pending    <= pending_next;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            rd_ptr     <= rd_ptr_next;
            fifo_count <= count_next;
            key_valid  <= (count_next != 3'd0);
            key_code   <= code_next;
            if ((rose & pending) != '0) begin
                overflow <= 1'b1;
            end
        end
    end

    // Event storage written at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; pointers and count gate every read of it.
        if (push) begin
            fifo_mem[wr_ptr] <= push_code;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: table-driven single-press vectors, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_key_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] key_raw = '0;
    logic       key_ready = 1'b0;
    logic       key_valid;
    logic [2:0] key_code;
    logic [5:0] key_level;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (key_raw),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .key_level  (key_level),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        key_raw   = '0;
        key_ready = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // Press one key long enough to debounce, then release and let it settle.
    task automatic press(input int k);
        key_raw[k] = 1'b1;
        tick(6);
        key_raw[k] = 1'b0;
        tick(12);
    endtask

    // ---------------- behavioural reference model ----------------
    // Sync value = raw seen two edges ago; a level flips on the D-th
    // consecutive edge of disagreement; a rise becomes pending one edge
    // later; the FIFO is a plain queue.
    bit         model_on = 1'b0;
    logic [5:0] m_hist1, m_hist2, m_level, m_rose, m_pend;
    int         m_run [6];
    int         m_q [$];
    logic       m_ovf;

    task automatic model_init();
        m_hist1 = '0; m_hist2 = '0; m_level = '0; m_rose = '0; m_pend = '0;
        m_ovf = 1'b0;
        for (int k = 0; k < 6; k++) m_run[k] = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit         pop, push;
        int         pidx;
        logic [5:0] new_pend, new_rose;
        pop  = (m_q.size() != 0) && key_ready;
        push = 1'b0;
        pidx = 0;
        if (m_pend != 0 && (m_q.size() < 4 || pop)) begin
            for (int k = 5; k >= 0; k--) if (m_pend[k]) pidx = k;
            push = 1'b1;
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(pidx);
        new_pend = m_pend;
        if (push) new_pend[pidx] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (m_rose[k]) begin
                if (m_pend[k]) m_ovf = 1'b1;
                else new_pend[k] = 1'b1;
            end
        end
        new_rose = '0;
        for (int k = 0; k < 6; k++) begin
            if (m_hist2[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == D) begin
                    m_level[k] = ~m_level[k];
                    m_run[k]   = 0;
                    if (m_level[k]) new_rose[k] = 1'b1;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_rose  = new_rose;
        m_pend  = new_pend;
        m_hist2 = m_hist1;
        m_hist1 = key_raw;
    endtask

    always @(posedge clk) begin
        if (model_on) model_step();
    end

    // ---------------- table of single-press vectors ----------------
    typedef struct {
        int key;
        int hold;
        int exp_events;
        int exp_code;
    } vec_t;

    vec_t vecs [8];
    int   glitch [12];
    int   ev, code, lvl_seen, ovf_seen;
    int   timer [6];

    initial begin
        vecs[0] = '{0, 1, 0, 0};
        vecs[1] = '{0, 3, 0, 0};
        vecs[2] = '{1, 4, 1, 1};
        vecs[3] = '{2, 5, 1, 2};
        vecs[4] = '{3, 9, 1, 3};
        vecs[5] = '{4, 2, 0, 0};
        vecs[6] = '{5, 4, 1, 5};
        vecs[7] = '{5, 12, 1, 5};
        glitch  = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0};

        // Reset state.
        tick(2);
        check("reset_valid", 32'(key_valid), 0);
        check("reset_code", 32'(key_code), 0);
        check("reset_count", 32'(fifo_count), 0);
        check("reset_level", 32'(key_level), 0);
        check("reset_ovf", 32'(overflow), 0);
        reset = 1'b0;

        // Table-driven presses of different lengths.
        key_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ev = 0; code = 0; lvl_seen = 0;
            key_raw[vecs[i].key] = 1'b1;
            for (int c = 1; c <= 40; c++) begin
                tick(1);
                if (c == vecs[i].hold) key_raw[vecs[i].key] = 1'b0;
                if (key_valid) begin ev++; code = 32'(key_code); end
                if (key_level[vecs[i].key]) lvl_seen = 1;
            end
            check($sformatf("vec%0d_events", i), 32'(ev), 32'(vecs[i].exp_events));
            check($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d_level", i), 32'(lvl_seen), 32'(vecs[i].exp_events));
        end

        // Glitch train on I1: no run reaches the debounce length.
        ev = 0; lvl_seen = 0;
        for (int i = 0; i < 12; i++) begin
            key_raw[0] = glitch[i][0];
            tick(1);
            if (key_valid) ev++;
            if (key_level[0]) lvl_seen = 1;
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (key_valid) ev++;
            if (key_level[0]) lvl_seen = 1;
        end
        check("glitch_events", 32'(ev), 0);
        check("glitch_level", 32'(lvl_seen), 0);
        check("glitch_count", 32'(fifo_count), 0);

        // Exact latency: key_valid on edge D+4 after the rise, for one cycle.
        do_reset();
        key_ready  = 1'b1;
        key_raw[2] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick(1);
            if (e >= 7) check($sformatf("lat_valid_e%0d", e), 32'(key_valid), (e == 8) ? 1 : 0);
            if (e == 8) check("lat_code", 32'(key_code), 2);
            if (e == 6) check("lat_level", 32'(key_level[2]), 1);
        end
        key_raw[2] = 1'b0;
        tick(12);

        // Simultaneous I2 and enter: lowest index first, back to back.
        key_raw[1] = 1'b1;
        key_raw[4] = 1'b1;
        tick(8);
        check("simul_first_valid", 32'(key_valid), 1);
        check("simul_first_code", 32'(key_code), 1);
        tick(1);
        check("simul_second_valid", 32'(key_valid), 1);
        check("simul_second_code", 32'(key_code), 4);
        tick(1);
        check("simul_after_valid", 32'(key_valid), 0);
        key_raw = '0;
        tick(12);

        // Fill the FIFO with ready low; enter stays pending; a repeat enter overflows.
        key_ready = 1'b0;
        for (int k = 0; k < 5; k++) press(k);
        check("full_count", 32'(fifo_count), 4);
        check("full_head", 32'(key_code), 0);
        check("full_no_ovf", 32'(overflow), 0);
        press(4);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(fifo_count), 4);
        key_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(key_valid), 1);
            check($sformatf("drain%0d_code", i), 32'(key_code), 32'(i));
            tick(1);
        end
        check("drain_empty", 32'(key_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Asynchronous reset with three queued events and a counter mid-count.
        key_ready = 1'b0;
        for (int k = 0; k < 3; k++) press(k);
        check("pre_reset_count", 32'(fifo_count), 3);
        key_raw[5] = 1'b1;
        key_raw[3] = 1'b1;
        tick(4);
        #2 reset = 1'b1;
        #1;
        check("async_valid", 32'(key_valid), 0);
        check("async_count", 32'(fifo_count), 0);
        check("async_ovf", 32'(overflow), 0);
        check("async_code", 32'(key_code), 0);
        check("async_level", 32'(key_level), 0);
        tick(3);
        key_raw[5] = 1'b0;
        reset      = 1'b0;
        key_ready  = 1'b1;
        ev = 0; code = 7;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (key_valid) begin ev++; code = 32'(key_code); end
        end
        check("held_events", 32'(ev), 1);
        check("held_code", 32'(code), 3);
        key_raw = '0;
        tick(12);

        // Randomized run against the model.
        do_reset();
        model_init();
        model_on = 1'b1;
        ovf_seen = 0;
        for (int k = 0; k < 6; k++) timer[k] = $urandom_range(1, 9);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick(1);
            check("rnd_valid", 32'(key_valid), 32'(m_q.size() != 0));
            check("rnd_code", 32'(key_code), (m_q.size() != 0) ? 32'(m_q[0]) : 0);
            check("rnd_level", 32'(key_level), 32'(m_level));
            check("rnd_count", 32'(fifo_count), 32'(m_q.size()));
            check("rnd_ovf", 32'(overflow), 32'(m_ovf));
            if (m_ovf) ovf_seen = 1;
            for (int k = 0; k < 6; k++) begin
                timer[k]--;
                if (timer[k] == 0) begin
                    key_raw[k] = ~key_raw[k];
                    timer[k]   = $urandom_range(1, 9);
                end
            end
            case ((cyc / 300) % 3)
                0:       key_ready = 1'b1;
                1:       key_ready = 1'($urandom_range(0, 1));
                default: key_ready = ($urandom_range(0, 7) == 0);
            endcase
        end
        model_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
